// File: rtl/pc_sequencer.sv
// pc_sequencer: 8-bit program-counter sequencer for an instruction fetch port.
// It issues fetch requests, advances the PC on every accepted fetch, and
// redirects to jump/call/return targets, holding late redirects as pending
// until the next accepted fetch.
// Optional feature: define PC_RETURN_STACK_EN to build in a STACK_DEPTH-entry
// LIFO return stack. Without it, call_req acts as jump_req, ret_req is
// ignored, and stack_err is tied low.
module pc_sequencer #(
   parameter logic [7:0] RESET_ADDR  = 8'h00,
   parameter int         STACK_DEPTH = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       jump_req,
   input  logic [7:0] jump_addr,
   input  logic       call_req,
   input  logic       ret_req,
   input  logic       stall,
   input  logic       fetch_ack,
   output logic       fetch_req,
   output logic [7:0] addr_out,
   output logic [7:0] nojump_addr,
   output logic       select,
   output logic       stack_err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      RD_JUMP = 2'd0,
      RD_CALL = 2'd1,
      RD_RET  = 2'd2
   } redirect_t;

   state_t     state;
   state_t     state_next;
   logic [7:0] pc;
   logic [7:0] next_pc;
   logic       ack_edge;

   // Redirect presented on the inputs this cycle (after priority).
   logic       pres_valid;
   redirect_t  pres_kind;

   // Redirect remembered from an earlier cycle, waiting for an accepted fetch.
   logic       pend_valid;
   redirect_t  pend_kind;
   logic [7:0] pend_addr;

   // Redirect that would take effect at an accepted fetch this cycle.
   logic       eff_valid;
   redirect_t  eff_kind;
   logic [7:0] eff_addr;

   assign addr_out    = pc;
   assign nojump_addr = pc + 8'd1;
   assign ack_edge    = (state == FETCH) && fetch_ack;

   assign eff_valid = pres_valid | pend_valid;
   assign eff_kind  = pres_valid ? pres_kind : pend_kind;
   assign eff_addr  = pres_valid ? jump_addr : pend_addr;
   assign select    = eff_valid;

`ifdef PC_RETURN_STACK_EN
   localparam int SP_W  = $clog2(STACK_DEPTH + 1);
   localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   logic [7:0]       stack_mem [STACK_DEPTH];
   logic [SP_W-1:0]  sp;
   logic [IDX_W-1:0] top_idx;
   logic [7:0]       stack_top;
   logic             stack_full;
   logic             stack_empty;
   logic             push;
   logic             pop;

   assign stack_full  = (sp == SP_W'(STACK_DEPTH));
   assign stack_empty = (sp == '0);
   assign top_idx     = IDX_W'(sp - SP_W'(1));
   assign stack_top   = stack_mem[top_idx];
   assign push        = ack_edge && eff_valid && (eff_kind == RD_CALL);
   assign pop         = ack_edge && eff_valid && (eff_kind == RD_RET);
`else
   logic [1:0] unused_cfg;

   assign stack_err  = 1'b0;
   assign unused_cfg = {ret_req, STACK_DEPTH > 0};
`endif

   // Resolve simultaneous redirect requests: ret over call over jump.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so
      // no path leaves it unassigned and no latch is inferred.
      pres_valid = 1'b0;
      pres_kind  = RD_JUMP;
`ifdef PC_RETURN_STACK_EN
      if (ret_req) begin
         pres_valid = 1'b1;
         pres_kind  = RD_RET;
      end else if (call_req) begin
         pres_valid = 1'b1;
         pres_kind  = RD_CALL;
      end else if (jump_req) begin
         pres_valid = 1'b1;
         pres_kind  = RD_JUMP;
      end
`else
      if (call_req || jump_req) begin
         pres_valid = 1'b1;
      end
`endif
   end

   // Choose the address the PC takes at an accepted fetch.
   always_comb begin
      next_pc = nojump_addr;
      if (eff_valid) begin
         case (eff_kind)
            RD_JUMP: next_pc = eff_addr;
            RD_CALL: next_pc = eff_addr;
            RD_RET: begin
`ifdef PC_RETURN_STACK_EN
               // An empty stack falls through to the sequential address.
               if (!stack_empty) next_pc = stack_top;
`endif
            end
            default: next_pc = nojump_addr;
         endcase
      end
   end

   // Sequencer FSM next state and fetch request.
   always_comb begin
      state_next = state;
      fetch_req  = 1'b0;
      case (state)
         IDLE, HOLD: state_next = stall ? HOLD : FETCH;
         FETCH: begin
            fetch_req = 1'b1;
            // The outstanding fetch is never withdrawn; stall only matters
            // once it has been accepted.
            if (fetch_ack) state_next = stall ? HOLD : FETCH;
         end
         default: state_next = IDLE;
      endcase
   end

   // State, PC and pending-redirect registers.
   always_ff @(posedge clk) begin
      // NOTE: registers are updated with non-blocking assignments so every
      // flop samples the pre-edge values, independent of statement order.
      if (reset) begin
         state      <= IDLE;
         pc         <= RESET_ADDR;
         pend_valid <= 1'b0;
         pend_kind  <= RD_JUMP;
         pend_addr  <= 8'h00;
      end else begin
         state <= state_next;
         if (ack_edge) begin
            pc         <= next_pc;
            pend_valid <= 1'b0;
         end else if (pres_valid) begin
            pend_valid <= 1'b1;
            pend_kind  <= pres_kind;
            pend_addr  <= jump_addr;
         end
      end
   end

`ifdef PC_RETURN_STACK_EN
   // Stack pointer and sticky overflow/underflow flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         sp        <= '0;
         stack_err <= 1'b0;
      end else if (push) begin
         if (stack_full) stack_err <= 1'b1;
         else            sp        <= sp + SP_W'(1);
      end else if (pop) begin
         if (stack_empty) stack_err <= 1'b1;
         else             sp        <= sp - SP_W'(1);
      end
   end

   // Return-address storage: the address after the calling fetch.
   always_ff @(posedge clk) begin
      // NOTE: the entries are not reset; emptying the stack only needs the
      // pointer cleared, and reset-free storage maps onto plain RAM/flops.
      if (!reset && push && !stack_full) begin
         stack_mem[IDX_W'(sp)] <= nojump_addr;
      end
   end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: self-checking bench for pc_sequencer. A behavioural model
// (plain integers and a queue for the return stack) tracks the expected PC,
// fetch phase, pending redirect and error flag; a compare process checks all
// outputs against it every cycle. Directed sequences pin literal addresses,
// then a long randomized run exercises stalls, acks, redirects and resets.
// Build with +define+PC_RETURN_STACK_EN to cover the return stack as well.
module tb_pc_sequencer;

   localparam logic [7:0] RESET_ADDR  = 8'h00;
   localparam int         STACK_DEPTH = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       jump_req;
   logic [7:0] jump_addr;
   logic       call_req;
   logic       ret_req;
   logic       stall;
   logic       fetch_ack;
   logic       fetch_req;
   logic [7:0] addr_out;
   logic [7:0] nojump_addr;
   logic       select;
   logic       stack_err;

   int n_checks = 0;
   int n_errors = 0;
   bit cmp_en   = 1'b0;

   pc_sequencer #(
      .RESET_ADDR (RESET_ADDR),
      .STACK_DEPTH(STACK_DEPTH)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .jump_req   (jump_req),
      .jump_addr  (jump_addr),
      .call_req   (call_req),
      .ret_req    (ret_req),
      .stall      (stall),
      .fetch_ack  (fetch_ack),
      .fetch_req  (fetch_req),
      .addr_out   (addr_out),
      .nojump_addr(nojump_addr),
      .select     (select),
      .stack_err  (stack_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // phase: 0 = waiting after reset, 1 = fetch outstanding, 2 = holding
   int m_phase;
   int m_pc;
   bit m_pend;
   int m_pend_kind;   // 1 jump, 2 call, 3 ret
   int m_pend_addr;
   int m_stack[$];
   bit m_err;

   // Redirect presented on the inputs right now (0 = none).
   function automatic int pres_kind();
`ifdef PC_RETURN_STACK_EN
      if (ret_req)  return 3;
      if (call_req) return 2;
`else
      if (call_req) return 1;
`endif
      if (jump_req) return 1;
      return 0;
   endfunction

   always @(posedge clk) begin
      int k;
      int a;
      int nxt;
      if (reset) begin
         m_phase = 0;
         m_pc    = RESET_ADDR;
         m_pend  = 1'b0;
         m_err   = 1'b0;
         m_stack.delete();
      end else begin
         k = pres_kind();
         a = jump_addr;
         if (m_phase == 1 && fetch_ack) begin
            if (k == 0 && m_pend) begin
               k = m_pend_kind;
               a = m_pend_addr;
            end
            nxt = (m_pc + 1) % 256;
            if (k == 1) begin
               nxt = a;
            end else if (k == 2) begin
               if (m_stack.size() < STACK_DEPTH) m_stack.push_back((m_pc + 1) % 256);
               else m_err = 1'b1;
               nxt = a;
            end else if (k == 3) begin
               if (m_stack.size() > 0) nxt = m_stack.pop_back();
               else m_err = 1'b1;
            end
            m_pc    = nxt;
            m_pend  = 1'b0;
            m_phase = stall ? 2 : 1;
         end else begin
            if (k != 0) begin
               m_pend      = 1'b1;
               m_pend_kind = k;
               m_pend_addr = a;
            end
            if (m_phase != 1) m_phase = stall ? 2 : 1;
         end
      end
   end

   // Compare every output against the model, away from the active edge.
   always @(negedge clk) begin
      if (cmp_en) begin
         check("fetch_req",   fetch_req,   (m_phase == 1) ? 1 : 0);
         check("addr_out",    addr_out,    m_pc);
         check("nojump_addr", nojump_addr, (m_pc + 1) % 256);
         check("select",      select,      (m_pend || pres_kind() != 0) ? 1 : 0);
         check("stack_err",   stack_err,   m_err);
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset     = 1'b1;
      stall     = 1'b0;
      fetch_ack = 1'b0;
      jump_req  = 1'b0;
      call_req  = 1'b0;
      ret_req   = 1'b0;
      jump_addr = 8'h00;
      step();
      cmp_en = 1'b1;
      step();

      // Reset state
      check("rst_addr",   addr_out,    8'h00);
      check("rst_nojump", nojump_addr, 8'h01);
      check("rst_fetch",  fetch_req,   1'b0);
      check("rst_select", select,      1'b0);
      check("rst_err",    stack_err,   1'b0);

      // Sequential fetch with ack every cycle
      reset = 1'b0;
      fetch_ack = 1'b1;
      step();
      check("seq_fetch0", fetch_req, 1'b1);
      check("seq_addr0",  addr_out,  8'h00);
      step();
      check("seq_addr1",  addr_out,  8'h01);
      step();
      check("seq_addr2",  addr_out,  8'h02);

      // Wrap from 8'hFF to 8'h00
      jump_req = 1'b1; jump_addr = 8'hFF; #1;
      check("wrap_select", select, 1'b1);
      step();
      jump_req = 1'b0; #1;
      check("wrap_ff",     addr_out,    8'hFF);
      check("wrap_nojump", nojump_addr, 8'h00);
      step();
      check("wrap_00",     addr_out,    8'h00);

      // Jump coincident with ack
      jump_req = 1'b1; jump_addr = 8'h40; #1;
      check("jmp_select", select, 1'b1);
      step();
      jump_req = 1'b0; #1;
      check("jmp_addr40", addr_out, 8'h40);
      check("jmp_sel0",   select,   1'b0);
      step();
      check("jmp_addr41", addr_out, 8'h41);

      // Ack withheld 3 cycles at 8'h10, jump pulsed in the first
      jump_req = 1'b1; jump_addr = 8'h10;
      step();
      jump_req = 1'b0; fetch_ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (i == 0) begin jump_req = 1'b1; jump_addr = 8'hF0; end
         #1;
         check("wait_fetch", fetch_req, 1'b1);
         check("wait_addr",  addr_out,  8'h10);
         check("wait_sel",   select,    1'b1);
         step();
         jump_req = 1'b0; jump_addr = 8'h00;
      end
      fetch_ack = 1'b1; #1;
      step();
      check("pend_applied", addr_out, 8'hF0);
      check("pend_cleared", select,   1'b0);

      // Stall during FETCH at 8'h20
      jump_req = 1'b1; jump_addr = 8'h20;
      step();
      jump_req = 1'b0; stall = 1'b1; fetch_ack = 1'b0; #1;
      check("stall_keepreq", fetch_req, 1'b1);
      step();
      check("stall_addr20", addr_out, 8'h20);
      fetch_ack = 1'b1;
      step();
      check("hold_req",  fetch_req, 1'b0);
      check("hold_addr", addr_out,  8'h21);
      step();
      check("hold_req2",  fetch_req, 1'b0);
      check("hold_addr2", addr_out,  8'h21);
      stall = 1'b0;
      step();
      check("resume_req",  fetch_req, 1'b1);
      check("resume_addr", addr_out,  8'h21);
      step();
      check("resume_22",   addr_out,  8'h22);

      // Reset during a pending jump
      fetch_ack = 1'b0; jump_req = 1'b1; jump_addr = 8'h55;
      step();
      jump_req = 1'b0; #1;
      check("pend_sel", select, 1'b1);
      reset = 1'b1;
      step();
      check("rst2_addr",  addr_out,  8'h00);
      check("rst2_sel",   select,    1'b0);
      check("rst2_fetch", fetch_req, 1'b0);
      reset = 1'b0; fetch_ack = 1'b1;
      step();
      step();
      check("rst2_lost", addr_out, 8'h01);

`ifdef PC_RETURN_STACK_EN
      // Call from 8'h05 to 8'h80, then return
      jump_req = 1'b1; jump_addr = 8'h05;
      step();
      jump_req = 1'b0; call_req = 1'b1; jump_addr = 8'h80;
      step();
      call_req = 1'b0; #1;
      check("call_addr", addr_out, 8'h80);
      ret_req = 1'b1;
      step();
      ret_req = 1'b0; #1;
      check("ret_addr", addr_out,  8'h06);
      check("ret_err",  stack_err, 1'b0);
      ret_req = 1'b1;
      step();
      ret_req = 1'b0; #1;
      check("underflow_addr", addr_out,  8'h07);
      check("underflow_err",  stack_err, 1'b1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      step();
      check("err_cleared", stack_err, 1'b0);
      for (int i = 0; i < 5; i++) begin
         call_req = 1'b1; jump_addr = 8'h90 + 8'(i);
         step();
         call_req = 1'b0; #1;
         check("nest_err",  stack_err, (i < 4) ? 1'b0 : 1'b1);
         check("nest_addr", addr_out,  8'h90 + 8'(i));
      end
`endif

      // Randomized traffic
      for (int i = 0; i < 4000; i++) begin
         reset     = ($urandom_range(63) == 0);
         stall     = ($urandom_range(3) == 0);
         fetch_ack = ($urandom_range(4) < 3);
         jump_req  = ($urandom_range(5) == 0);
         call_req  = ($urandom_range(11) == 0);
         ret_req   = ($urandom_range(11) == 0);
         if ($urandom_range(3) == 0) jump_addr = 8'hFF - 8'($urandom_range(2));
         else                        jump_addr = 8'($urandom_range(255));
         step();
      end

      reset = 1'b0; jump_req = 1'b0; call_req = 1'b0; ret_req = 1'b0;
      stall = 1'b0; fetch_ack = 1'b0;
      step();
      @(negedge clk);
      #1;
      cmp_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter: RESET_ADDR, 8'h00, fetch address loaded by reset.
REQ-002 Parameter: STACK_DEPTH, 4, return-stack entries (used only with PC_RETURN_STACK_EN).
REQ-003 clk  input  1  rising-edge clock, sole clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 jump_req  input  1  request a jump to jump_addr.
REQ-006 jump_addr  input  8  jump target address.
REQ-007 call_req  input  1  jump to jump_addr, saving return address.
REQ-008 ret_req  input  1  return to the most recently saved address.
REQ-009 stall  input  1  hold sequencing; no new fetch is issued.
REQ-010 fetch_ack  input  1  instruction memory accepts the current fetch.
REQ-011 fetch_req  output  1  fetch request for addr_out.
REQ-012 addr_out  output  8  current fetch address (PC).
REQ-013 nojump_addr  output  8  addr_out + 1, mod 256.
REQ-014 select  output  1  next-address mux select: 1 = jump/call/ret target, 0 = nojump_addr.
REQ-015 stack_err  output  1  sticky return-stack overflow/underflow flag.

Function
REQ-016 States: IDLE, FETCH, HOLD; 2-bit encoded.
REQ-017 IDLE: entered on reset; fetch_req=0; next cycle -> FETCH if stall=0, else HOLD.
REQ-018 FETCH: fetch_req=1; addr_out and fetch_req stable until fetch_ack sampled high at a rising edge.
REQ-019 On ack edge: PC loads next address; addr_out updates the cycle after ack (1-cycle latency); -> HOLD if stall=1 that edge, else remain FETCH.
REQ-020 HOLD: fetch_req=0, PC held; -> FETCH on first edge with stall=0.
REQ-021 Next address: pending redirect target if one exists, else nojump_addr; 8'hFF wraps to 8'h00.
REQ-022 Redirect (jump/call/ret) arriving in any state without same-edge ack is latched as pending; applied at the next ack edge; newer redirect overwrites pending.
REQ-023 Redirect coincident with ack: applied at that ack edge.
REQ-024 Priority among simultaneous redirects: ret_req > call_req > jump_req.
REQ-025 select = 1 whenever a redirect is pending or presented this cycle, else 0; combinational.
REQ-026 stall in FETCH does not withdraw fetch_req; outstanding fetch completes first.
REQ-027 fetch_ack outside FETCH ignored.

Reset
REQ-028 reset has priority over all inputs at a rising edge.
REQ-029 Reset values: state=IDLE, addr_out=RESET_ADDR, nojump_addr=RESET_ADDR+1, fetch_req=0, select=0, stack_err=0, pending cleared, stack emptied.
REQ-030 Reset mid-fetch abandons the outstanding fetch; no ack is awaited.

Configuration
REQ-031 Macro PC_RETURN_STACK_EN compiles in a STACK_DEPTH-entry LIFO return stack.
REQ-032 With macro: call pushes (PC of calling fetch)+1 at its applying ack edge; ret pops to its target.
REQ-033 With macro: push when full discarded, target still taken, stack_err set; pop when empty treated as sequential (nojump_addr), stack_err set.
REQ-034 Without macro: call_req behaves as jump_req, ret_req ignored, stack_err constant 0; ports remain.

Verification
REQ-035 Reset, stall=0, ack every cycle -> addr_out 00,01,02,...; at 8'hFF next addr 8'h00.
REQ-036 jump_req=1, jump_addr=8'h40 with ack -> select=1 that cycle, addr_out=8'h40 next cycle, then 8'h41.
REQ-037 Ack withheld 3 cycles at addr 8'h10, jump_req pulsed to 8'hF0 in cycle 1 -> fetch_req/addr_out stable, on ack addr_out=8'hF0.
REQ-038 stall=1 during FETCH at 8'h20 -> fetch completes on ack, then HOLD (fetch_req=0, addr 8'h21) until stall=0.
REQ-039 PC_RETURN_STACK_EN: call to 8'h80 from 8'h05, ret -> addr 8'h80 then 8'h06; five nested calls with depth 4 -> stack_err=1.
REQ-040 Reset asserted during pending jump -> addr_out=8'h00, select=0, pending lost.
